// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single synchronous write port of a 2**A_WIDTH x D_WIDTH register file
//   between N_REQ write sources using masked round-robin arbitration, one grant per
//   clock. All outputs are registered and drive the register file pins directly.
//
// Optional feature: define REGFILE_ARB_LOCK_EN to add the lock port. A requester that
//   is currently granted, still requesting and holding lock wins again unconditionally
//   (back-to-back writes); the round-robin pointer does not move while it does.
//
// Ports
//   clk        posedge clock
//   clr        synchronous reset, active-high; drops any pending grant
//   req        per-requester write request
//   req_addr   packed target addresses, slice i = [i*A_WIDTH +: A_WIDTH]
//   req_data   packed write data, slice i = [i*D_WIDTH +: D_WIDTH]
//   lock       per-requester lock (REGFILE_ARB_LOCK_EN only)
//   gnt        one-hot grant, high for the cycle in which requester i's write issues
//   write      register file write enable
//   writeaddr  register file write address
//   data_in    register file write data
//   busy       registered: an eligible request was seen last cycle
module regfile_write_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned A_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [N_REQ-1:0]           lock,
`endif
  output logic [N_REQ-1:0]           gnt,
  output logic                       write,
  output logic [A_WIDTH-1:0]         writeaddr,
  output logic [D_WIDTH-1:0]         data_in,
  output logic                       busy
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               write_q;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic               busy_q;

  logic [N_REQ-1:0]   elig;
  logic [N_REQ-1:0]   lock_hold;
  logic               lock_hit;
  logic               win_found;
  logic [PtrW-1:0]    win_idx;
  logic [PtrW-1:0]    lock_idx;
  logic [PtrW:0]      scan_sum;
  logic [PtrW-1:0]    scan_idx;
  logic [PtrW:0]      ptr_inc;

  // The granted requester is masked so a held req is never granted twice in a row.
  assign elig = req & ~gnt_q;

`ifdef REGFILE_ARB_LOCK_EN
  assign lock_hold = gnt_q & req & lock;
`else
  assign lock_hold = '0;
`endif
  assign lock_hit = |lock_hold;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    lock_idx  = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    ptr_inc   = '0;
    gnt_d     = '0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    ptr_d     = ptr_q;

    // gnt_q is one-hot, so at most one lock holder exists.
    for (int i = 0; i < N_REQ; i++) begin
      if (lock_hold[i]) lock_idx = PtrW'(i);
    end

    if (lock_hit) begin
      win_found = 1'b1;
      win_idx   = lock_idx;
    end else begin
      // Scan ptr, ptr+1, ... wrapping modulo N_REQ; first eligible wins.
      for (int k = 0; k < N_REQ; k++) begin
        scan_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
        if (scan_sum >= (PtrW+1)'(N_REQ)) scan_sum = scan_sum - (PtrW+1)'(N_REQ);
        scan_idx = scan_sum[PtrW-1:0];
        if (!win_found && elig[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
    end

    if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt_d[i]) begin
          waddr_d = req_addr[i*A_WIDTH +: A_WIDTH];
          wdata_d = req_data[i*D_WIDTH +: D_WIDTH];
        end
      end
      if (!lock_hit) begin
        ptr_inc = {1'b0, win_idx} + 1'b1;
        if (ptr_inc == (PtrW+1)'(N_REQ)) ptr_inc = '0;
        ptr_d = ptr_inc[PtrW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ptr_q   <= '0;
      gnt_q   <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      write_q <= win_found;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= win_found;
    end
  end

  assign gnt       = gnt_q;
  assign write     = write_q;
  assign writeaddr = waddr_q;
  assign data_in   = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 1 << AW;
`ifdef REGFILE_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              clr;
  logic [N-1:0]      req;
  logic [N-1:0]      lock;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic              write;
  logic [AW-1:0]     writeaddr;
  logic [DW-1:0]     data_in;
  logic              busy;

  regfile_write_arbiter #(.N_REQ(N), .D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk       (clk),
    .clr       (clr),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
`ifdef REGFILE_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .write     (write),
    .writeaddr (writeaddr),
    .data_in   (data_in),
    .busy      (busy)
  );

  // Register file fed by the arbiter outputs.
  logic          rf_clr;
  logic [DW-1:0] rf [NR];
  always_ff @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else if (write) begin
      rf[writeaddr] <= data_in;
    end
  end

  // Reference model state.
  int            m_gnt;
  int            m_ptr;
  bit            m_write;
  bit            m_busy;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mrf [NR];
  int            wait_cnt [N];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Advances the model across one clock edge from the current inputs.
  task automatic model_step();
    int win;
    bit held;
    if (rf_clr) begin
      for (int i = 0; i < NR; i++) mrf[i] = '0;
    end else if (m_write) begin
      mrf[m_waddr] = m_data;
    end
    if (clr) begin
      m_gnt = -1; m_ptr = 0; m_write = 0; m_busy = 0; m_waddr = '0; m_data = '0;
      return;
    end
    win  = -1;
    held = LockEn && (m_gnt >= 0) && req[m_gnt] && lock[m_gnt];
    if (held) begin
      win = m_gnt;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (win < 0 && req[i] && i != m_gnt) win = i;
      end
    end
    m_busy  = (win >= 0);
    m_write = (win >= 0);
    if (win >= 0) begin
      m_waddr = req_addr[win*AW +: AW];
      m_data  = req_data[win*DW +: DW];
      if (!held) m_ptr = (win + 1) % N;
    end
    m_gnt = win;
  endtask

  task automatic tick();
    logic [N-1:0] eg;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
    check("gnt", 32'(gnt), 32'(eg));
    check("write", 32'(write), 32'(m_write));
    check("busy", 32'(busy), 32'(m_busy));
    if (m_write) begin
      check("writeaddr", 32'(writeaddr), 32'(m_waddr));
      check("data_in", 32'(data_in), 32'(m_data));
    end
    check("onehot", 32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic do_clear();
    clr = 1'b1; req = '0; lock = '0;
    tick();
    clr = 1'b0;
  endtask

  logic [N-1:0] exp_seq [4];

  initial begin
    m_gnt = -1; m_ptr = 0; m_write = 0; m_busy = 0; m_waddr = '0; m_data = '0;
    for (int i = 0; i < NR; i++) mrf[i] = '0;
    req_addr = '0; req_data = '0; lock = '0;
    rf_clr = 1'b1;

    // 1: clr overrides requests, then grants in order 0,1,2,3.
    clr = 1'b1; req = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 8), DW'(8'h10 * i + 1));
    tick();
    rf_clr = 1'b0;
    check("t1_clr_gnt", 32'(gnt), 32'd0);
    check("t1_clr_write", 32'(write), 32'd0);
    check("t1_clr_busy", 32'(busy), 32'd0);
    clr = 1'b0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_order", 32'(gnt), 32'(exp_seq[k]));
    end

    // 2: single requester, 1 write per 2 cycles.
    do_clear();
    set_req(2, 4'h5, 8'hA3);
    tick();
    check("t2_gnt", 32'(gnt), 32'b0100);
    check("t2_write", 32'(write), 32'd1);
    check("t2_addr", 32'(writeaddr), 32'h5);
    check("t2_data", 32'(data_in), 32'hA3);
    tick();
    check("t2_masked", 32'(gnt), 32'd0);
    check("t2_reg5", 32'(rf[5]), 32'hA3);
    tick();
    check("t2_regrant", 32'(gnt), 32'b0100);

    // 3: two requesters alternate at full rate.
    do_clear();
    set_req(0, 4'h1, 8'h01);
    set_req(3, 4'h3, 8'h03);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t3_alt", 32'(gnt), (k % 2 == 0) ? 32'b0001 : 32'b1000);
      check("t3_write", 32'(write), 32'd1);
    end

    // 4: clr while a grant is pending drops it and resets ptr.
    do_clear();
    set_req(0, 4'h1, 8'h11);
    set_req(1, 4'hE, 8'h5A);
    set_req(2, 4'h2, 8'h22);
    set_req(3, 4'h4, 8'h44);
    tick();
    check("t4_first", 32'(gnt), 32'b0001);
    clr = 1'b1;
    tick();
    check("t4_clr_write", 32'(write), 32'd0);
    check("t4_clr_gnt", 32'(gnt), 32'd0);
    clr = 1'b0;
    tick();
    check("t4_ptr0", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    check("t4_regE", 32'(rf[14]), 32'h0);

`ifdef REGFILE_ARB_LOCK_EN
    // 5: lock gives back-to-back grants to the holder.
    do_clear();
    set_req(0, 4'h6, 8'h60);
    set_req(1, 4'h7, 8'h70);
    tick();
    check("t5_g0", 32'(gnt), 32'b0001);
    tick();
    check("t5_g1", 32'(gnt), 32'b0010);
    lock[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data[1*DW +: DW] = DW'(8'h71 + k);
      tick();
      check("t5_locked", 32'(gnt), 32'b0010);
    end
    lock[1] = 1'b0;
    tick();
    check("t5_release", 32'(gnt), 32'b0001);
`endif

    // 6: random traffic with the req/gnt handshake.
    do_clear();
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      tick();
      if (m_gnt >= 0) begin
        check("fair", 32'(wait_cnt[m_gnt] <= N - 1), 32'd1);
        for (int i = 0; i < N; i++) if (i != m_gnt && req[i]) wait_cnt[i]++;
        wait_cnt[m_gnt] = 0;
        if ($urandom_range(1, 0) == 1) req[m_gnt] = 1'b0;
        else set_req(m_gnt, AW'($urandom), DW'($urandom));
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && i != m_gnt && $urandom_range(2, 0) == 0) begin
          set_req(i, AW'($urandom), DW'($urandom));
          wait_cnt[i] = 0;
        end
      end
    end
    req = '0;
    tick();
    tick();
    for (int i = 0; i < NR; i++) check("rf_final", 32'(rf[i]), 32'(mrf[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
